// File: rtl/serial_slave_port.sv
// Bit-serial bus responder: deserialises address/write data, drives a synchronous
// memory port, and serialises read data back on srdata/svalid.
module serial_slave_port #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  swdata,
   input  logic                  smode,
   input  logic                  mvalid,
   output logic                  srdata,
   output logic                  svalid,
   output logic                  sready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wen,
   output logic                  mem_ren,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW   = $clog2(MAXW) + 1;
   // Address bit 0 is taken in IDLE, so ADDR only counts the remaining bits.
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 2);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RREQ, S_RWAIT, S_RDATA
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] wdata_sh_q, wdata_sh_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] rdata_sh_q, rdata_sh_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         addr_sh_q   <= '0;
         mem_addr_q  <= '0;
         wdata_sh_q  <= '0;
         mem_wdata_q <= '0;
         rdata_sh_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         addr_sh_q   <= addr_sh_d;
         mem_addr_q  <= mem_addr_d;
         wdata_sh_q  <= wdata_sh_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_sh_q  <= rdata_sh_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      addr_sh_d   = addr_sh_q;
      mem_addr_d  = mem_addr_q;
      wdata_sh_d  = wdata_sh_q;
      mem_wdata_d = mem_wdata_q;
      rdata_sh_d  = rdata_sh_q;

      case (state_q)
         S_IDLE: begin
            if (mvalid) begin
               addr_sh_d = {swdata, addr_sh_q[ADDR_WIDTH-1:1]};
               mode_d    = smode;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (mvalid) begin
               addr_sh_d = {swdata, addr_sh_q[ADDR_WIDTH-1:1]};
               cnt_d     = cnt_q + CW'(1);
               if (cnt_q == ADDR_LAST) begin
                  mem_addr_d = addr_sh_d;
                  state_d    = mode_q ? S_WDATA : S_RREQ;
               end
            end
         end
         S_WDATA: begin
            if (mvalid) begin
               wdata_sh_d = {swdata, wdata_sh_q[DATA_WIDTH-1:1]};
               cnt_d      = cnt_q + CW'(1);
               if (cnt_q == DATA_LAST) begin
                  mem_wdata_d = wdata_sh_d;
                  state_d     = S_WRITE;
               end
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_RREQ:  state_d = S_RWAIT;
         S_RWAIT: begin
            rdata_sh_d = mem_rdata;
            state_d    = S_RDATA;
         end
         S_RDATA: begin
            rdata_sh_d = rdata_sh_q >> 1;
            cnt_d      = cnt_q + CW'(1);
            if (cnt_q == DATA_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Counter always restarts from zero when a new phase begins.
      if (state_d != state_q) cnt_d = '0;
   end

   assign sready    = (state_q == S_IDLE);
   assign svalid    = (state_q == S_RDATA);
   assign srdata    = (state_q == S_RDATA) & rdata_sh_q[0];
   assign mem_wen   = (state_q == S_WRITE);
   assign mem_ren   = (state_q == S_RREQ);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
- Responder-side endpoint of the bit-serial system bus: the slave counterpart to the demo master's serial initiator.
- Deserialises the address and write data from the bus, drives a local synchronous memory port, and serialises read data back with svalid.
- Sits between the address decoder's per-slave mvalid line and a slave-local BRAM or register file.
- slave_with_bram-style devices instantiate it as their bus front end.

Parameters:
- ADDR_WIDTH, 12: slave-local address bits, sent LSB first.
- DATA_WIDTH, 8: data word bits, sent LSB first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- swdata  in  1  serial address/write-data bit from the bus.
- smode  in  1  0 = read, 1 = write; sampled with address bit 0.
- mvalid  in  1  bit-valid from the decoder, already qualified for this slave.
- srdata  out  1  serial read-data bit.
- svalid  out  1  read-data bit valid.
- sready  out  1  1 = idle and able to accept a new transfer.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wen  out  1  one-cycle write strobe.
- mem_ren  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_WIDTH  read data, valid exactly 1 cycle after mem_ren.

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; bit counter and shift registers clear.
  - Outputs: srdata=0, svalid=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, sready=1.
  - Reset mid-transfer aborts the transfer; no memory strobe is issued afterwards.
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA.
- IDLE (sready=1):
  - mvalid=1 captures swdata as address bit 0 and latches smode, then goes to ADDR.
  - mvalid=0 stays in IDLE.
- ADDR:
  - Each cycle with mvalid=1 shifts in the next address bit, LSB first.
  - Cycles with mvalid=0 are gaps: hold state, no shift.
  - After bit ADDR_WIDTH-1: go to WDATA if the latched mode is 1, else RREQ.
- WDATA: shifts DATA_WIDTH bits on mvalid=1, same gap rule; after the last bit go to WRITE.
- WRITE: one cycle with mem_wen=1, mem_addr and mem_wdata stable; then IDLE.
- RREQ: one cycle with mem_ren=1 and mem_addr stable; then RWAIT.
- RWAIT: loads mem_rdata into the read shift register; then RDATA.
- RDATA:
  - Exactly DATA_WIDTH consecutive cycles with svalid=1.
  - srdata is read bit k in the k-th cycle, LSB first, no gaps.
  - Then IDLE.
- Latency: let N be the cycle of the last serial input bit.
  - Write: mem_wen at N+1; sready=1 at N+2.
  - Read: mem_ren at N+1; svalid at N+3 through N+2+DATA_WIDTH; sready=1 at N+3+DATA_WIDTH.
- sready=0 in every state except IDLE.
- mvalid, swdata and smode are ignored in WRITE, RREQ, RWAIT and RDATA.
- smode changes after address bit 0 have no effect.
- The bit counter is ceil(log2(max(ADDR_WIDTH, DATA_WIDTH)))+1 bits wide and clears on every state change. No wrap-around is possible.
- Outside RDATA: svalid=0 and srdata=0.
- Outside WRITE/RREQ: mem_wen=0 and mem_ren=0.
- mem_addr and mem_wdata hold their last value between transfers.

Test Plan (ADDR_WIDTH=12, DATA_WIDTH=8, 1-cycle BRAM model):
- Write then read: write 0xA5 to addr 0x123 with contiguous bits. Expect mem_wen one cycle with addr 0x123, data 0xA5, then sready=1 next cycle. Read of 0x123 returns srdata bits 1,0,1,0,0,1,0,1 with svalid high for exactly 8 cycles, starting 3 cycles after the last address bit.
- Gapped write: write 0x3C to 0xFFF with mvalid dropped 2 cycles after address bit 5 and 3 cycles after data bit 2. Expect the memory to receive addr 0xFFF, data 0x3C; no extra or missing bits.
- Mode latch: read of addr 0x000 with smode toggled to 1 after bit 0. Expect mem_ren, no mem_wen, and an 8-bit svalid burst of the stored value.
- Busy ignore: during a read's RDATA phase, drive mvalid=1 with random swdata. Expect no state disturbance, sready=0 until burst end, then 1.
- Reset mid-transfer: assert rst after data bit 4 of a write to 0x010. Expect no mem_wen ever for that write, all outputs at reset values, and sready=1. A following read of 0x010 returns the prior contents.
- Back-to-back: start a new write in the same cycle sready returns to 1. Expect it is accepted with address bit 0 captured in that cycle.
